// File: rtl/pio_out_blink_pkg.sv
// rtl/pio_out_blink_pkg.sv - register map constants for pio_out_blink
package pio_out_blink_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd5;

endpackage

// File: rtl/pio_blink_timer.sv
// rtl/pio_blink_timer.sv - blink counter producing a phase that toggles every period cycles
module pio_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period,
    input  logic             restart,
    output logic             phase
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // The >= compare makes a shrunken period wrap at once instead of running to 2^CNT_W.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (restart || period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= period - CNT_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pio_out_blink.sv
// rtl/pio_out_blink.sv - Avalon-MM output PIO with optional blink (enabled by PIO_OUT_BLINK_EN)
module pio_out_blink #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    import pio_out_blink_pkg::*;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             restart;
    logic             phase;

    assign restart = wr_en && (address == ADDR_PERIOD);

    pio_blink_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en && address == ADDR_BLINK_MASK) mask_d = wd;
        if (wr_en && address == ADDR_PERIOD)     period_d = writedata[CNT_W-1:0];
        out_d = data_q ^ (mask_q & {WIDTH{phase}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
    assign out_d = data_q;
`endif

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default:       data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            out_q  <= RESET_VALUE;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_q);
`ifdef PIO_OUT_BLINK_EN
            ADDR_BLINK_MASK: readdata = 32'(mask_q);
            ADDR_PERIOD:     readdata = 32'(period_q);
            ADDR_STATUS:     readdata = {31'b0, phase};
`else
            ADDR_BLINK_MASK, ADDR_PERIOD, ADDR_STATUS: readdata = '0;
`endif
            default:         readdata = '0;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_pio_out_blink.sv
// tb/tb_pio_out_blink.sv - randomized self-checking bench for pio_out_blink against a behavioural model
module tb_pio_out_blink;

    localparam int          W  = 10;
    localparam logic [9:0]  RV = 10'h155;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    int checks = 0;
    int errors = 0;

    pio_out_blink #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, cycles elapsed in the current phase, and the
    // pin value that was registered at the last edge.
    logic [W-1:0] m_data, m_mask, m_out;
    int           m_period, m_cnt;
    bit           m_phase, m_valid, w;

    initial m_valid = 0;

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
`ifdef PIO_OUT_BLINK_EN
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_period);
            3'd3:    return {31'b0, m_phase};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        w = chipselect && !write_n;
        if (reset) begin
            m_data = RV; m_mask = '0; m_period = 0; m_cnt = 0; m_phase = 0; m_out = RV;
            m_valid = 1;
        end else begin
`ifdef PIO_OUT_BLINK_EN
            m_out = m_data ^ (m_mask & {W{m_phase}});
            if (w && address == 3'd2) begin
                m_cnt = 0; m_phase = 0;
            end else if (m_period == 0) begin
                m_cnt = 0; m_phase = 0;
            end else if (m_cnt + 1 >= m_period) begin
                m_cnt = 0; m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
            if (w && address == 3'd1) m_mask = writedata[W-1:0];
            if (w && address == 3'd2) m_period = int'(writedata[23:0]);
`else
            m_out = m_data;
`endif
            if (w) begin
                case (address)
                    3'd0: m_data = writedata[W-1:0];
                    3'd4: m_data = m_data | writedata[W-1:0];
                    3'd5: m_data = m_data & ~writedata[W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("out_port", 32'(out_port), 32'(m_out));
            check("readdata", readdata, exp_rd(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    endtask

    int changes;
    int n;

    initial begin
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h3FF;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        #1;
        check("reset_out", 32'(out_port), 32'h155);
        check("reset_rd0", readdata, 32'h155);

        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h00F);
        #1;
        check("outset_rd", readdata, 32'h0FF);
        check("outset_lag", 32'(out_port), 32'h0F0);
        @(posedge clk); #1;
        check("outset_out", 32'(out_port), 32'h0FF);
        wr(3'd5, 32'h030);
        #1;
        check("outclr_rd", readdata, 32'h0CF);
        @(posedge clk); #1;
        check("outclr_out", 32'(out_port), 32'h0CF);

`ifdef PIO_OUT_BLINK_EN
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h3);
        wr(3'd2, 32'h4);
        address = 3'd3;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("blink_phase", readdata, 32'((k / 4) % 2));
            check("blink_out", 32'(out_port), (k == 0) ? 32'h0 : ((((k - 1) / 4) % 2) != 0 ? 32'h3 : 32'h0));
            @(posedge clk); #1;
        end
        address = 3'd0;

        wr(3'd2, 32'd10);
        repeat (6) @(posedge clk);
        wr(3'd2, 32'd3);
        address = 3'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("shrink_phase", readdata, (k == 3) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end

        n = 0;
        while (readdata[0] == 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("phase_wait", 32'(readdata[0]), 32'h1);
        chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h0;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        @(posedge clk); #1;
        check("period0_restore", 32'(out_port), 32'h0);
        changes = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (out_port !== 10'h000) changes++;
        end
        check("period0_steady", changes, 0);
`else
        wr(3'd2, 32'd5);
        address = 3'd2;
        #1;
        check("period_ro", readdata, 32'h0);
        changes = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_port !== 10'h0CF) changes++;
        end
        check("no_toggle", changes, 0);
        address = 3'd0;
`endif

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            chipselect = 1'($urandom % 4 != 0);
            write_n    = 1'($urandom % 3 == 0);
            address    = 3'($urandom % 8);
            writedata  = (address == 3'd2) ? ($urandom % 8) : $urandom;
            reset      = 1'($urandom % 80 == 0);
        end
        @(posedge clk); #2;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_out_blink.md
PIO_OUT_BLINK -- requirements
Module: pio_out_blink

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the number of output bits (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the DATA register value after reset (WIDTH bits).
REQ-003 The block SHALL have parameter CNT_W, default 24, meaning the width of the PERIOD register and the blink counter (legal range 1..32).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port address, input, 3 bits: Avalon-MM slave word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: read data, zero-latency, zero-extended.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: the driven pins.

Function
REQ-012 The register map SHALL be: 0 DATA (R/W); 1 BLINK_MASK (R/W); 2 PERIOD (R/W, CNT_W bits); 3 STATUS (RO, bit0 = phase); 4 OUTSET (WO); 5 OUTCLEAR (WO); 6-7 reserved.
REQ-013 A write SHALL occur on a clk edge when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used, or [CNT_W-1:0] for PERIOD.
REQ-014 An OUTSET write SHALL perform DATA <= DATA | wd; an OUTCLEAR write SHALL perform DATA <= DATA & ~wd; each updates DATA in a single cycle.
REQ-015 readdata SHALL be combinational from address, with readdata = zero-extended register value; addresses 3 (bits other than bit0), 4, 5, 6 and 7 SHALL read 0.
REQ-016 out_port SHALL equal DATA ^ (BLINK_MASK & {WIDTH{phase}}) and SHALL be registered (one clk after the state change).
REQ-017 When PERIOD=0, blinking SHALL be disabled: cnt held at 0 and phase held at 0.
REQ-018 When PERIOD!=0, cnt SHALL increment each cycle; when cnt >= PERIOD-1, cnt SHALL return to 0 and phase SHALL toggle, so each phase lasts PERIOD cycles.
REQ-019 A PERIOD write SHALL force cnt=0 and phase=0 in the same cycle, overriding any wrap.
REQ-020 A BLINK_MASK write SHALL NOT alter cnt or phase.
REQ-021 Reducing PERIOD below the current cnt value SHALL cause a wrap on the next edge (the >= compare, with no 2^CNT_W run-away); REQ-019 normally preempts this case.
REQ-022 Writes to RO or reserved addresses SHALL be ignored.

Reset
REQ-023 While reset=1 at a clk edge: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, cnt=0, phase=0, out_port=RESET_VALUE.
REQ-024 Reset SHALL take priority over a simultaneous write.
REQ-025 Reset asserted mid-blink SHALL take effect on that edge with no residual phase.

Configuration
REQ-026 When macro PIO_OUT_BLINK_EN is defined, BLINK_MASK, PERIOD, the counter and the phase logic SHALL be compiled in.
REQ-027 When PIO_OUT_BLINK_EN is undefined: addresses 1-3 SHALL read 0 and ignore writes; out_port SHALL equal registered DATA; and no counter logic SHALL be present.

Structure
REQ-028 A package pio_out_blink_pkg SHALL hold the register address constants (ADDR_DATA..ADDR_OUTCLEAR) and the address width constant.
REQ-029 The counter/phase logic SHALL be a sub-module pio_blink_timer (ports: clk, reset, period, restart, phase).

Verification
REQ-030 Scenario: reset with RESET_VALUE=10'h155 -> out_port=0x155 and readdata@0=0x155.
REQ-031 Scenario: write DATA=0x0F0, then OUTSET 0x00F, then OUTCLEAR 0x030 -> DATA reads 0x0FF then 0x0CF; out_port follows one cycle after each write.
REQ-032 Scenario: DATA=0x000, MASK=0x003, PERIOD=4 -> out_port toggles 0x000/0x003 every 4 cycles, STATUS bit0 tracks the toggle.
REQ-033 Scenario: while blinking with PERIOD=10 and cnt=7, write PERIOD=3 -> phase=0 immediately, next toggle after exactly 3 cycles.
REQ-034 Scenario: write PERIOD=0 during phase=1 -> out_port returns to DATA next cycle and stays steady for 100 cycles.
REQ-035 Scenario: reset asserted concurrently with a DATA=0x3FF write -> DATA=RESET_VALUE; with the macro undefined, PERIOD=5 write followed by a read of address 2 -> 0 and out_port never toggles.
